// File: rtl/rx_byte_assembler_pkg.sv
// Shared types and defaults for the USB full-speed receive byte assembler.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;
    localparam int         STUFF_LEN_DEF = 6;

endpackage

// File: rtl/rx_byte_assembler_flex_counter.sv
// Small wrap-around counter: counts 0..rollover_val then back to 0.
// rollover_flag marks the terminal count so the caller can act on the final increment.
module flex_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count_out,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (count_enable) begin
            count_next = (count_reg == rollover_val) ? '0 : count_reg + 1'b1;
        end
    end

    assign count_out     = count_reg;
    assign rollover_flag = (count_reg == rollover_val);

endmodule

// File: rtl/rx_byte_assembler.sv
// USB FS receive byte assembler: checks SYNC, strips stuffed bits and builds
// LSB-first bytes from the NRZI-decoded bit stream.
module rx_byte_assembler
    import usb_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         STUFF_LEN = STUFF_LEN_DEF
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       d_orig,
    input  logic       shift_enable,
    input  logic       eop,
    output logic [7:0] rx_data,
    output logic       byte_valid,
    output logic       sync_ok,
    output logic       rx_active,
    output logic       stuff_err,
    output logic       align_err
);

    localparam logic [2:0] STUFF_CNT = 3'(STUFF_LEN);

    rx_state_t  state_reg, state_next;
    logic [7:0] shreg_reg, shreg_next;
    logic [2:0] ones_reg, ones_next;
    logic [7:0] rx_data_reg, rx_data_next;
    logic       byte_valid_reg, byte_valid_next;
    logic       sync_ok_reg, sync_ok_next;
    logic       rx_active_reg, rx_active_next;
    logic       stuff_err_reg, stuff_err_next;
    logic       align_err_reg, align_err_next;

    logic       cnt_clear;
    logic       cnt_en;
    logic [2:0] bit_cnt;
    logic       last_bit;

    flex_counter #(.WIDTH(3)) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (cnt_en),
        .rollover_val (3'd7),
        .count_out    (bit_cnt),
        .rollover_flag(last_bit)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg      <= IDLE;
            shreg_reg      <= 8'h00;
            ones_reg       <= 3'd0;
            rx_data_reg    <= 8'h00;
            byte_valid_reg <= 1'b0;
            sync_ok_reg    <= 1'b0;
            rx_active_reg  <= 1'b0;
            stuff_err_reg  <= 1'b0;
            align_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shreg_reg      <= shreg_next;
            ones_reg       <= ones_next;
            rx_data_reg    <= rx_data_next;
            byte_valid_reg <= byte_valid_next;
            sync_ok_reg    <= sync_ok_next;
            rx_active_reg  <= rx_active_next;
            stuff_err_reg  <= stuff_err_next;
            align_err_reg  <= align_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        shreg_next      = shreg_reg;
        ones_next       = ones_reg;
        rx_data_next    = rx_data_reg;
        byte_valid_next = 1'b0;
        sync_ok_next    = 1'b0;
        align_err_next  = 1'b0;
        stuff_err_next  = stuff_err_reg;
        cnt_clear       = 1'b0;
        cnt_en          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = SYNC;
                    cnt_clear      = 1'b1;
                    ones_next      = 3'd0;
                    shreg_next     = 8'h00;
                    stuff_err_next = 1'b0;
                end
            end
            SYNC, DATA: begin
                if (eop) begin
                    state_next = IDLE;
                    cnt_clear  = 1'b1;
                    align_err_next = (state_reg == DATA) && (bit_cnt != 3'd0);
                end else if (shift_enable) begin
                    if ((state_reg == DATA) && (ones_reg == STUFF_CNT)) begin
                        // Stuff slot: a 0 is dropped silently, a 1 is a line error.
                        ones_next = 3'd0;
                        if (d_orig) begin
                            stuff_err_next = 1'b1;
                            state_next     = ERR;
                        end
                    end else begin
                        shreg_next = {d_orig, shreg_reg[7:1]};
                        // Saturate so a long run of 1s in a bad SYNC cannot wrap.
                        ones_next  = d_orig ? ((ones_reg == 3'd7) ? 3'd7 : ones_reg + 3'd1) : 3'd0;
                        cnt_en     = 1'b1;
                        if (last_bit) begin
                            if (state_reg == SYNC) begin
                                if (shreg_next == SYNC_BYTE) begin
                                    state_next   = DATA;
                                    sync_ok_next = 1'b1;
                                end else begin
                                    state_next = ERR;
                                end
                            end else begin
                                rx_data_next    = shreg_next;
                                byte_valid_next = 1'b1;
                            end
                        end
                    end
                end
            end
            ERR: begin
                if (eop) begin
                    state_next = IDLE;
                    cnt_clear  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        rx_active_next = (state_next == SYNC) || (state_next == DATA);
    end

    assign rx_data    = rx_data_reg;
    assign byte_valid = byte_valid_reg;
    assign sync_ok    = sync_ok_reg;
    assign rx_active  = rx_active_reg;
    assign stuff_err  = stuff_err_reg;
    assign align_err  = align_err_reg;

endmodule

// File: tb/tb_rx_byte_assembler.sv
// Scoreboard bench for rx_byte_assembler: directed packets push expected pulses,
// a negedge monitor pops and compares whenever the DUT raises a pulse.
module tb_rx_byte_assembler;

    logic       clk;
    logic       n_rst;
    logic       start;
    logic       d_orig;
    logic       shift_enable;
    logic       eop;
    logic [7:0] rx_data;
    logic       byte_valid;
    logic       sync_ok;
    logic       rx_active;
    logic       stuff_err;
    logic       align_err;

    rx_byte_assembler dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .d_orig      (d_orig),
        .shift_enable(shift_enable),
        .eop         (eop),
        .rx_data     (rx_data),
        .byte_valid  (byte_valid),
        .sync_ok     (sync_ok),
        .rx_active   (rx_active),
        .stuff_err   (stuff_err),
        .align_err   (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         kind;   // 0 = sync_ok, 1 = byte_valid, 2 = align_err
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared = 0;
    int   n_failed   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Monitor: each pulse seen must match the head of the expectation queue.
    always @(negedge clk) begin
        if (n_rst && (sync_ok || byte_valid || align_err)) begin
            int   kind;
            exp_t e;
            kind = sync_ok ? 0 : (byte_valid ? 1 : 2);
            if (exp_q.size() == 0) begin
                n_compared++;
                n_failed++;
                $display("FAIL unexpected_pulse: got kind %0d (rx_data %02h) expected none", kind, rx_data);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", 8'(kind), 8'(e.kind));
                if (kind == 1) check("rx_data", rx_data, e.data);
                $display("monitor: kind %0d rx_data %02h", kind, rx_data);
            end
        end
    end

    task automatic push(input int kind, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        d_orig       = b;
        shift_enable = 1'b1;
        @(posedge clk); #1;
        shift_enable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) send_bit(bits[i]);
    endtask

    task automatic pulse_start(input logic with_strobe);
        start        = 1'b1;
        shift_enable = with_strobe;
        d_orig       = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        shift_enable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_eop(input logic with_strobe);
        eop          = 1'b1;
        shift_enable = with_strobe;
        d_orig       = 1'b1;
        @(posedge clk); #1;
        eop          = 1'b0;
        shift_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0; start = 1'b0; d_orig = 1'b0; shift_enable = 1'b0; eop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_flags", {2'b00, byte_valid, sync_ok, rx_active, stuff_err, align_err, 1'b0}, 8'h00);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Packet 1: SYNC + 0xA5, clean eop
        pulse_start(1'b0);
        check("p1_active", {7'd0, rx_active}, 8'h01);
        push(0, 8'h00);
        send_bits(32'h80, 8);
        push(1, 8'hA5);
        send_bits(32'hA5, 8);
        pulse_eop(1'b0);
        check("p1_idle", {7'd0, rx_active}, 8'h00);
        $display("txn p1: SYNC + A5 done");

        // Packet 2: 0xFF with one stuffed 0 after five data 1s
        pulse_start(1'b0);
        push(0, 8'h00);
        send_bits(32'h80, 8);
        push(1, 8'hFF);
        send_bits(32'h1DF, 9);
        check("p2_stuff_err", {7'd0, stuff_err}, 8'h00);
        pulse_eop(1'b0);
        $display("txn p2: SYNC + FF (stuffed) done");

        // Packet 3: stuff violation
        pulse_start(1'b0);
        push(0, 8'h00);
        send_bits(32'h80, 8);
        send_bits(32'h3F, 6);
        check("p3_stuff_err", {7'd0, stuff_err}, 8'h01);
        check("p3_err_state", {7'd0, rx_active}, 8'h00);
        send_bits(32'h5, 8);
        pulse_eop(1'b0);
        check("p3_sticky", {7'd0, stuff_err}, 8'h01);
        check("p3_rx_data", rx_data, 8'hFF);
        pulse_start(1'b0);
        check("p3_cleared", {7'd0, stuff_err}, 8'h00);
        pulse_eop(1'b0);
        $display("txn p3: stuff error done");

        // Packet 4: corrupted SYNC 0x81
        pulse_start(1'b0);
        send_bits(32'h81, 8);
        check("p4_err_state", {7'd0, rx_active}, 8'h00);
        pulse_eop(1'b0);
        check("p4_rx_data", rx_data, 8'hFF);
        $display("txn p4: bad SYNC done");

        // Packet 5: 0x3C then 3 bits, eop coincident with a strobe
        pulse_start(1'b0);
        push(0, 8'h00);
        send_bits(32'h80, 8);
        push(1, 8'h3C);
        send_bits(32'h3C, 8);
        send_bits(32'h5, 3);
        push(2, 8'h00);
        pulse_eop(1'b1);
        check("p5_idle", {7'd0, rx_active}, 8'h00);
        check("p5_rx_data", rx_data, 8'h3C);
        $display("txn p5: align error done");

        // Packet 6: reset mid-byte, then 0x5A with start coincident with a strobe
        pulse_start(1'b0);
        push(0, 8'h00);
        send_bits(32'h80, 8);
        send_bits(32'hB, 4);
        n_rst = 1'b0;
        #1;
        check("p6_rst_rx_data", rx_data, 8'h00);
        check("p6_rst_active", {7'd0, rx_active}, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        pulse_start(1'b1);
        push(0, 8'h00);
        send_bits(32'h80, 8);
        push(1, 8'h5A);
        send_bits(32'h5A, 8);
        pulse_eop(1'b0);
        check("p6_rx_data", rx_data, 8'h5A);
        $display("txn p6: reset recovery + 5A done");

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
